// File: rtl/uart_pkg.sv
// Shared types and character helpers for the UART status-frame scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    STROBE    = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_e;

  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_SEMI  = 8'h3B;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Character handshake between the frame scheduler and the serial transmitter.
interface uart_tx_scheduler_if;
  logic [7:0] o_tx_byte;
  logic       o_tx_dv;
  logic       i_tx_active;
  logic       i_tx_done;

  modport master (output o_tx_byte, output o_tx_dv, input i_tx_active, input i_tx_done);
  modport slave  (input o_tx_byte, input o_tx_dv, output i_tx_active, output i_tx_done);
endinterface

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: search starts just after the last granted index,
// pointer moves only when a grant is taken.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_vld
);

  logic [IW-1:0] ptr_q;

  always_comb begin
    int c;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    c       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(ptr_q) + i) % NUM_REQ;
      if (!gnt_vld && req[c[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = c[IW-1:0];
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr_q <= IW'(NUM_REQ - 1);
    else if (en && gnt_vld)  ptr_q <= gnt_idx;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Collects per-requester status payloads and serialises them as ASCII hex
// frames ':' HEX... ';'. Define UART_TX_SCHED_CHECKSUM_EN to append a sum byte.
import uart_pkg::*;

module uart_tx_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int PAYLOAD_BYTES = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 i_req,
  input  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] i_payload,
  output logic [NUM_REQ-1:0]                 o_busy,
  output logic [NUM_REQ-1:0]                 o_overrun,
  uart_tx_scheduler_if.master                tx
);

  localparam int PW   = PAYLOAD_BYTES * 8;
  localparam int NIBS = 2 * PAYLOAD_BYTES;
`ifdef UART_TX_SCHED_CHECKSUM_EN
  localparam int FLEN = NIBS + 4;
`else
  localparam int FLEN = NIBS + 2;
`endif
  localparam int IW   = $clog2(NUM_REQ);
  localparam int IDXW = $clog2(FLEN);
  localparam int NIBW = $clog2(NIBS);

  sched_state_e state_q, state_d;

  logic [NUM_REQ-1:0][PW-1:0] buf_q;
  logic [NUM_REQ-1:0]         pending_q, overrun_q, inflight_q;
  logic [NUM_REQ-1:0]         gnt, take;
  logic [IW-1:0]              gnt_idx;
  logic                       gnt_vld;
  logic [PW-1:0]              frame_q;
  logic [IDXW-1:0]            idx_q;
  logic                       last_char;
  logic [NIBW-1:0]            nib_sel;
  logic [7:0]                 cur_char;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pending_q),
    .en      (state_q == GRANT),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign take      = (state_q == GRANT) ? gnt : '0;
  assign last_char = (idx_q == IDXW'(FLEN - 1));
  assign o_busy    = pending_q | inflight_q;
  assign o_overrun = overrun_q;

  // A request landing on its own grant cycle is a fresh capture, not an overrun:
  // the set term wins over the grant clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= (pending_q & ~take) | i_req;
      overrun_q <= overrun_q | (i_req & pending_q & ~take);
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_buf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        buf_q[k] <= '0;
      else if (i_req[k]) buf_q[k] <= i_payload[k*PW +: PW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      idx_q      <= '0;
      inflight_q <= '0;
    end else begin
      case (state_q)
        GRANT: if (gnt_vld) begin
          frame_q    <= buf_q[gnt_idx];
          idx_q      <= '0;
          inflight_q <= gnt;
        end
        WAIT_DONE: if (tx.i_tx_done) begin
          idx_q <= idx_q + 1'b1;
          if (last_char) inflight_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (|pending_q) state_d = GRANT;
      GRANT:     state_d = gnt_vld ? STROBE : IDLE;
      STROBE:    if (!tx.i_tx_active) state_d = WAIT_DONE;
      WAIT_DONE: if (tx.i_tx_done) begin
        if (!last_char)      state_d = STROBE;
        else if (|pending_q) state_d = GRANT;
        else                 state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

`ifdef UART_TX_SCHED_CHECKSUM_EN
  function automatic logic [7:0] byte_sum(input logic [PW-1:0] p);
    logic [7:0] s;
    s = '0;
    for (int b = 0; b < PAYLOAD_BYTES; b++) s = s + p[b*8 +: 8];
    return s;
  endfunction

  logic [7:0] cksum;
  assign cksum = byte_sum(frame_q);
`endif

  // Character 1 is the most significant nibble of the payload.
  always_comb begin
    cur_char = CHAR_SEMI;
    nib_sel  = '0;
    if (idx_q == '0) begin
      cur_char = CHAR_COLON;
    end else if (idx_q <= IDXW'(NIBS)) begin
      nib_sel  = NIBW'(NIBS - int'(idx_q));
      cur_char = hex_char(frame_q[int'(nib_sel)*4 +: 4]);
    end
`ifdef UART_TX_SCHED_CHECKSUM_EN
    else if (idx_q == IDXW'(NIBS + 1)) cur_char = hex_char(cksum[7:4]);
    else if (idx_q == IDXW'(NIBS + 2)) cur_char = hex_char(cksum[3:0]);
`endif
  end

  always_comb begin
    tx.o_tx_dv   = 1'b0;
    tx.o_tx_byte = 8'h00;
    if (state_q == STROBE) begin
      tx.o_tx_byte = cur_char;
      tx.o_tx_dv   = !tx.i_tx_active;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a 10-cycle transmitter model.
module tb_uart_tx_scheduler;

`ifdef UART_TX_SCHED_CHECKSUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] payload;
  logic [3:0]  busy, overrun;
  logic        force_active;

  uart_tx_scheduler_if tx_if ();

  uart_tx_scheduler #(.NUM_REQ(4), .PAYLOAD_BYTES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (req),
    .i_payload (payload),
    .o_busy    (busy),
    .o_overrun (overrun),
    .tx        (tx_if)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int req_cyc = 0;
  int first_dv_cyc = 0;
  logic [7:0] rxq[$];
  bit outstanding = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // transmitter: busy for 10 cycles after each strobe, then a done pulse
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  int   m_cnt    = 0;
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (tx_if.o_tx_dv) begin
      m_active <= 1'b1;
      m_cnt    <= 10;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt    <= 0;
      m_active <= 1'b0;
      m_done   <= 1'b1;
    end
  end
  assign tx_if.i_tx_active = m_active | force_active;
  assign tx_if.i_tx_done   = m_done;

  always @(negedge clk) begin
    if (tx_if.i_tx_done) outstanding = 1'b0;
    if (rst_n && tx_if.o_tx_dv) begin
      chk("dv_while_active", 64'(tx_if.i_tx_active), 64'd0);
      chk("dv_without_done", 64'(outstanding), 64'd0);
      if (rxq.size() == 0) first_dv_cyc = cyc;
      rxq.push_back(tx_if.o_tx_byte);
      outstanding = 1'b1;
    end
  end

  // h = four payload characters, ck = two checksum characters
  function automatic logic [63:0] fr(input logic [31:0] h, input logic [15:0] ck);
`ifdef UART_TX_SCHED_CHECKSUM_EN
    return {8'h3A, h, ck, 8'h3B};
`else
    return {16'h0000, 8'h3A, h, 8'h3B} | {48'h0, ck & 16'h0000};
`endif
  endfunction

  task automatic send(input int k, input logic [15:0] p);
    @(negedge clk);
    payload[k*16 +: 16] = p;
    req     = 4'b0000;
    req[k]  = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(rxq.size() >= n), 64'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] exp);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < FLEN; i++)
      if (rxq.size() > 0) v = {v[55:0], rxq.pop_front()};
    chk(tag, v, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rxq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; payload = '0; force_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dv",      64'(tx_if.o_tx_dv),   64'd0);
    chk("rst_byte",    64'(tx_if.o_tx_byte), 64'h00);
    chk("rst_busy",    64'(busy),            64'h0);
    chk("rst_overrun", 64'(overrun),         64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single request, latency and frame text
    send(0, 16'hA51F);
    wait_bytes("single_first", 1, 100);
    chk("single_latency", 64'(first_dv_cyc - req_cyc), 64'd3);
    chk("single_busy_flight", 64'(busy), 64'b0001);
    wait_bytes("single_all", FLEN, 400);
    pop_chk("single_frame", fr(32'h41353146, 16'h4334));
    repeat (15) @(negedge clk);
    chk("single_busy_done", 64'(busy), 64'h0);

    // round-robin from reset, then again from pointer left at 3
    do_reset();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      payload = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
      req = 4'b1111;
      @(negedge clk);
      req = 4'b0000;
      chk("rr_busy", 64'(busy), 64'b1111);
      wait_bytes("rr_all", 4*FLEN, 3000);
      pop_chk("rr_k0", fr(32'h31323334, 16'h3436));
      pop_chk("rr_k1", fr(32'h35363738, 16'h4345));
      pop_chk("rr_k2", fr(32'h39414243, 16'h3536));
      pop_chk("rr_k3", fr(32'h44454630, 16'h4345));
      repeat (15) @(negedge clk);
    end

    // overrun on k=2 while k=1 is in flight
    send(1, 16'h5678);
    wait_bytes("ovr_k1_start", 1, 100);
    send(2, 16'h0001);
    send(2, 16'h0002);
    wait_bytes("ovr_all", 2*FLEN, 1000);
    pop_chk("ovr_k1", fr(32'h35363738, 16'h4345));
    pop_chk("ovr_k2", fr(32'h30303032, 16'h3032));
    repeat (30) @(negedge clk);
    chk("ovr_no_extra", 64'(rxq.size()), 64'd0);
    chk("ovr_flag", 64'(overrun), 64'b0100);

    // backpressure: transmitter held busy for 50 cycles
    force_active = 1'b1;
    send(3, 16'hDEF0);
    repeat (50) @(negedge clk);
    chk("bp_no_dv", 64'(rxq.size()), 64'd0);
    chk("bp_busy", 64'(busy), 64'b1000);
    force_active = 1'b0;
    wait_bytes("bp_all", FLEN, 400);
    pop_chk("bp_frame", fr(32'h44454630, 16'h4345));
    repeat (15) @(negedge clk);
    chk("ovr_sticky", 64'(overrun), 64'b0100);

    // reset after the third character
    send(0, 16'h1234);
    wait_bytes("rst_mid_3", 3, 200);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dv", 64'(tx_if.o_tx_dv), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_overrun", 64'(overrun), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_silent", 64'(rxq.size()), 64'd3);
    rxq.delete();
    send(1, 16'h9ABC);
    wait_bytes("rst_after_all", FLEN, 400);
    pop_chk("rst_after_frame", fr(32'h39414243, 16'h3536));
    repeat (15) @(negedge clk);

    // second request for k=2 lands exactly on its GRANT cycle
    send(2, 16'h0A0B);
    send(2, 16'h0C0D);
    wait_bytes("grant_hit_all", 2*FLEN, 1000);
    pop_chk("grant_hit_old", fr(32'h30413042, 16'h3135));
    pop_chk("grant_hit_new", fr(32'h30433044, 16'h3139));
    chk("grant_hit_no_ovr", 64'(overrun), 64'h0);
    repeat (15) @(negedge clk);

    // checksum wrap case
    send(0, 16'hFF02);
    wait_bytes("ff02_all", FLEN, 400);
    pop_chk("ff02_frame", fr(32'h46463032, 16'h3031));
    repeat (15) @(negedge clk);
    chk("final_idle_busy", 64'(busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
